// File: rtl/sortn_stream_if.sv
// Stream bundle for sortn_stream: sample input channel, sorted output
// channel with last-flag, and the busy status line.
interface sortn_stream_if #(
  parameter int WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_last;
  logic                    busy;

  // Source/sink side (drives samples in, accepts sorted samples out)
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, busy
  );

  // Sorter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/sortn_stream.sv
// sortn_stream: loads a frame of N signed samples, sorts it in place with an
// odd-even transposition network (one pass per clock, N passes), then streams
// the sorted frame out with backpressure and a last-flag.
module sortn_stream #(
  parameter int WIDTH   = 8,
  parameter int N       = 8,
  parameter int DESCEND = 0
) (
  input  logic          clk,
  input  logic          rst,
  sortn_stream_if.slave s
);

  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = AW + 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_SORT = 2'd1;
  localparam logic [1:0] ST_OUT  = 2'd2;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [1:0]              r_state;
  logic [IW-1:0]           r_idx;
  logic [IW-1:0]           r_pass;
  logic signed [WIDTH-1:0] r_mem  [N];
  logic signed [WIDTH-1:0] w_next [N];
  logic                    w_last_idx;
  logic [AW-1:0]           w_addr;

  assign w_last_idx = (r_idx == LAST_IDX);
  assign w_addr     = r_idx[AW-1:0];

  // One compare-exchange pass: even pass pairs (0,1),(2,3)...; odd pass pairs
  // (1,2),(3,4)... so r[0] and r[N-1] hold. Pairs within a pass never overlap.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_next[i] = r_mem[i];
    end
    for (int unsigned i = 0; i + 1 < N; i++) begin
      if (i[0] == r_pass[0]) begin
        if ((DESCEND != 0) ? (r_mem[i] < r_mem[i+1]) : (r_mem[i] > r_mem[i+1])) begin
          w_next[i]   = r_mem[i+1];
          w_next[i+1] = r_mem[i];
        end
      end
    end
  end

  // Frame state machine: LOAD accepts N samples, SORT runs N passes, OUT drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_LOAD;
      r_idx   <= '0;
      r_pass  <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (s.in_valid) begin
            r_mem[w_addr] <= s.in_data;
            if (w_last_idx) begin
              r_idx   <= '0;
              r_pass  <= '0;
              r_state <= ST_SORT;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        ST_SORT: begin
          for (int unsigned i = 0; i < N; i++) begin
            r_mem[i] <= w_next[i];
          end
          if (r_pass == LAST_IDX) begin
            r_idx   <= '0;
            r_state <= ST_OUT;
          end else begin
            r_pass <= r_pass + 1'b1;
          end
        end
        ST_OUT: begin
          if (s.out_ready) begin
            if (w_last_idx) begin
              r_idx   <= '0;
              r_state <= ST_LOAD;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_LOAD;
        end
      endcase
    end
  end

  // Status and data outputs decode only registered state and index.
  always_comb begin
    s.in_ready  = (r_state == ST_LOAD);
    s.out_valid = (r_state == ST_OUT);
    s.out_last  = (r_state == ST_OUT) && w_last_idx;
    s.busy      = (r_state != ST_LOAD);
    s.out_data  = r_mem[w_addr];
  end

endmodule

// File: tb/tb_sortn_stream.sv
// Bench for sortn_stream: table-driven frames plus directed corner sequences,
// checked through per-DUT expected-output queues.
module tb_sortn_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sortn_stream_if #(.WIDTH(8)) b0 ();
  sortn_stream_if #(.WIDTH(8)) b1 ();
  sortn_stream_if #(.WIDTH(4)) b2 ();

  sortn_stream #(.WIDTH(8), .N(8), .DESCEND(0)) u_asc  (.clk(clk), .rst(rst), .s(b0));
  sortn_stream #(.WIDTH(8), .N(8), .DESCEND(1)) u_desc (.clk(clk), .rst(rst), .s(b1));
  sortn_stream #(.WIDTH(4), .N(2), .DESCEND(0)) u_n2   (.clk(clk), .rst(rst), .s(b2));

  typedef logic [0:7][7:0] frame_t;
  typedef struct packed { frame_t in_s; frame_t asc; frame_t dsc; } vec_t;
  typedef struct packed { logic signed [7:0] d; logic last; } exp_t;
  typedef struct packed { logic signed [3:0] d; logic last; } exp2_t;

  exp_t  q0[$];
  exp_t  q1[$];
  exp2_t q2[$];
  vec_t  tbl[4];

  int n_tests  = 0;
  int n_fail   = 0;
  int rdy_mode = 0;  // 0: out_ready high, 1: random, 2: low

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic frame_t row(input int a0, input int a1, input int a2, input int a3,
                                 input int a4, input int a5, input int a6, input int a7);
    frame_t f;
    f[0] = a0[7:0]; f[1] = a1[7:0]; f[2] = a2[7:0]; f[3] = a3[7:0];
    f[4] = a4[7:0]; f[5] = a5[7:0]; f[6] = a6[7:0]; f[7] = a7[7:0];
    return f;
  endfunction

  // Reference: stable insertion sort on signed values
  function automatic frame_t model_sort(input frame_t d, input bit desc);
    logic signed [7:0] v[8];
    logic signed [7:0] t;
    frame_t r;
    int j;
    for (int i = 0; i < 8; i++) v[i] = d[i];
    for (int i = 1; i < 8; i++) begin
      t = v[i];
      j = i - 1;
      while (j >= 0 && (desc ? (v[j] < t) : (v[j] > t))) begin
        v[j+1] = v[j];
        j--;
      end
      v[j+1] = t;
    end
    for (int i = 0; i < 8; i++) r[i] = v[i];
    return r;
  endfunction

  function automatic logic [7:0] rand_s8();
    case ($urandom_range(0, 7))
      0:       return 8'h80;
      1:       return 8'h7F;
      2, 3:    return 8'($urandom_range(0, 3));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // out_ready for all DUTs, updated 2 time units after each rising edge
  initial begin
    logic r;
    b0.out_ready = 1'b1; b1.out_ready = 1'b1; b2.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      r = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      b0.out_ready = r; b1.out_ready = r; b2.out_ready = r;
    end
  end

  // Output monitors: every valid cycle (stalled or not) must show the queue head
  always @(negedge clk) begin
    if (!rst) begin
      if (b0.out_valid) begin
        chk("asc_have_expected", (q0.size() > 0), 1);
        if (q0.size() > 0) begin
          chk("asc_data", b0.out_data, q0[0].d);
          chk("asc_last", b0.out_last, q0[0].last);
          if (b0.out_ready) void'(q0.pop_front());
        end
      end
      if (b1.out_valid) begin
        chk("desc_have_expected", (q1.size() > 0), 1);
        if (q1.size() > 0) begin
          chk("desc_data", b1.out_data, q1[0].d);
          chk("desc_last", b1.out_last, q1[0].last);
          if (b1.out_ready) void'(q1.pop_front());
        end
      end
      if (b2.out_valid) begin
        chk("n2_have_expected", (q2.size() > 0), 1);
        if (q2.size() > 0) begin
          chk("n2_data", b2.out_data, q2[0].d);
          chk("n2_last", b2.out_last, q2[0].last);
          if (b2.out_ready) void'(q2.pop_front());
        end
      end
    end
  end

  // Drive cnt samples into both N=8 DUTs in lockstep; push expectations for full frames
  task automatic send8(input frame_t d, input int cnt, input int gap_pct,
                       input frame_t ea, input frame_t ed, output int wait1);
    logic ok;
    int waited;
    wait1 = 0;
    for (int i = 0; i < cnt; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        b0.in_valid = 1'b0; b1.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      b0.in_valid = 1'b1; b0.in_data = d[i];
      b1.in_valid = 1'b1; b1.in_data = d[i];
      ok = 1'b0;
      waited = 0;
      while (!ok && waited < 1000) begin
        ok = b0.in_ready;
        @(posedge clk); #1;
        waited++;
      end
      if (!ok) chk("in_accept_timeout", ok, 1);
      if (i == 0) wait1 = waited;
    end
    b0.in_valid = 1'b0; b1.in_valid = 1'b0;
    if (cnt == 8) begin
      for (int i = 0; i < 8; i++) begin
        q0.push_back('{d: ea[i], last: (i == 7)});
        q1.push_back('{d: ed[i], last: (i == 7)});
      end
    end
  endtask

  task automatic send2(input logic [3:0] a, input logic [3:0] b, input int gap_pct);
    logic ok;
    int waited;
    int lat;
    logic [3:0] d[2];
    d[0] = a; d[1] = b;
    for (int i = 0; i < 2; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        b2.in_valid = 1'b0;
        @(posedge clk); #1;
      end
      b2.in_valid = 1'b1; b2.in_data = d[i];
      ok = 1'b0;
      waited = 0;
      while (!ok && waited < 1000) begin
        ok = b2.in_ready;
        @(posedge clk); #1;
        waited++;
      end
      if (!ok) chk("n2_accept_timeout", ok, 1);
    end
    b2.in_valid = 1'b0;
    if ($signed(a) > $signed(b)) begin
      q2.push_back('{d: b, last: 1'b0});
      q2.push_back('{d: a, last: 1'b1});
    end else begin
      q2.push_back('{d: a, last: 1'b0});
      q2.push_back('{d: b, last: 1'b1});
    end
    lat = 0;
    while (!b2.out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("n2_latency", lat, 2);
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain", q0.size() + q1.size() + q2.size(), 0);
  endtask

  task automatic wait_out_valid();
    int t = 0;
    while (!b0.out_valid && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("out_valid_seen", b0.out_valid, 1);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk({tag, "_in_ready"},  b0.in_ready, 1);
    chk({tag, "_out_valid"}, b0.out_valid, 0);
    chk({tag, "_out_last"},  b0.out_last, 0);
    chk({tag, "_busy"},      b0.busy, 0);
    chk({tag, "_out_data"},  b0.out_data, 0);
    q0.delete(); q1.delete(); q2.delete();
  endtask

  initial begin
    int w;
    int lat;
    frame_t d;
    frame_t zero_f;
    zero_f = '0;

    b0.in_valid = 1'b0; b0.in_data = '0;
    b1.in_valid = 1'b0; b1.in_data = '0;
    b2.in_valid = 1'b0; b2.in_data = '0;

    tbl[0].in_s = row(5, -3, 127, -128, 0, 7, 7, -1);
    tbl[0].asc  = row(-128, -3, -1, 0, 5, 7, 7, 127);
    tbl[0].dsc  = row(127, 7, 7, 5, 0, -1, -3, -128);
    tbl[1].in_s = row(1, 2, 3, 4, 5, 6, 7, 8);
    tbl[1].asc  = row(1, 2, 3, 4, 5, 6, 7, 8);
    tbl[1].dsc  = row(8, 7, 6, 5, 4, 3, 2, 1);
    tbl[2].in_s = row(8, 7, 6, 5, 4, 3, 2, 1);
    tbl[2].asc  = row(1, 2, 3, 4, 5, 6, 7, 8);
    tbl[2].dsc  = row(8, 7, 6, 5, 4, 3, 2, 1);
    tbl[3].in_s = row(-128, 127, -128, 127, 0, 0, -1, 1);
    tbl[3].asc  = row(-128, -128, -1, 0, 0, 1, 127, 127);
    tbl[3].dsc  = row(127, 127, 1, 0, 0, -1, -128, -128);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready",  b0.in_ready, 1);
    chk("rst_out_valid", b0.out_valid, 0);
    chk("rst_out_last",  b0.out_last, 0);
    chk("rst_busy",      b0.busy, 0);
    chk("rst_out_data",  b0.out_data, 0);
    chk("rst_n2_in_ready", b2.in_ready, 1);
    chk("rst_n2_busy",     b2.busy, 0);

    // Table frames, out_ready high, with first-output latency
    rdy_mode = 0;
    for (int r = 0; r < 4; r++) begin
      send8(tbl[r].in_s, 8, 0, tbl[r].asc, tbl[r].dsc, w);
      chk("sort_busy", b0.busy, 1);
      lat = 0;
      while (!b0.out_valid && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      chk("first_out_latency", lat, 8);
      wait_drain();
    end

    // Back-to-back frames with in_valid held: frame 2 accepted 2N+1 edges after frame 1's last input
    send8(tbl[0].in_s, 8, 0, tbl[0].asc, tbl[0].dsc, w);
    send8(tbl[3].in_s, 8, 0, tbl[3].asc, tbl[3].dsc, w);
    chk("b2b_first_accept_wait", w, 17);
    wait_drain();

    // Random frames with input gaps and random backpressure
    rdy_mode = 1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 8; i++) d[i] = rand_s8();
      send8(d, 8, 30, model_sort(d, 1'b0), model_sort(d, 1'b1), w);
    end
    wait_drain();

    // Reset after 3 inputs
    rdy_mode = 0;
    send8(tbl[1].in_s, 3, 0, zero_f, zero_f, w);
    pulse_reset("rst_midload");
    send8(tbl[0].in_s, 8, 0, tbl[0].asc, tbl[0].dsc, w);
    wait_drain();

    // Reset mid-SORT
    send8(tbl[2].in_s, 8, 0, tbl[2].asc, tbl[2].dsc, w);
    repeat (3) @(posedge clk);
    #1;
    pulse_reset("rst_midsort");
    send8(tbl[3].in_s, 8, 0, tbl[3].asc, tbl[3].dsc, w);
    wait_drain();

    // Reset after 2 outputs with out_ready low (stalled head checked meanwhile)
    rdy_mode = 2;
    send8(tbl[0].in_s, 8, 0, tbl[0].asc, tbl[0].dsc, w);
    wait_out_valid();
    rdy_mode = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rdy_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    chk("stall_queue_left", q0.size(), 6);
    pulse_reset("rst_midout");
    rdy_mode = 0;
    send8(tbl[2].in_s, 8, 0, tbl[2].asc, tbl[2].dsc, w);
    wait_drain();

    // N=2, WIDTH=4: directed extremes/duplicates, then random
    send2(4'h7, 4'h8, 0);
    send2(4'h8, 4'h7, 0);
    send2(4'h3, 4'h3, 0);
    send2(4'hF, 4'h0, 0);
    wait_drain();
    rdy_mode = 1;
    for (int f = 0; f < 60; f++) begin
      send2(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 25);
    end
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d, failed %0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
